// File: rtl/btn_debounce_sync.sv
// Button conditioner: polarity fix, N-flop synchroniser, hold-time debounce FSM,
// registered level/edge strobes and a wrapping press counter.
module btn_debounce_sync #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int COUNT_W         = 8
) (
   input  logic               Clk,
   input  logic               Resetn,
   input  logic               BtnIn,
   input  logic               CountClr,
   output logic               Level,
   output logic               Rise,
   output logic               Fall,
   output logic               Busy,
   output logic [COUNT_W-1:0] PressCount
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_LOW_CHK  = 2'd1,
      S_HIGH     = 2'd2,
      S_HIGH_CHK = 2'd3
   } state_t;

   logic                   w_b;
   logic                   w_s;
   logic [SYNC_STAGES-1:0] r_sync;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_level;
   logic                   w_busy;

   logic                   r_level;
   logic                   r_rise;
   logic                   r_fall;
   logic                   r_busy;
   logic [COUNT_W-1:0]     r_press;

   // Resetting the chain to 0 means "released" regardless of board polarity.
   assign w_b = ACTIVE_LOW ? ~BtnIn : BtnIn;
   assign w_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], w_b};
      end
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         r_state <= S_LOW;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise      = 1'b0;
      w_fall      = 1'b0;
      case (r_state)
         S_LOW: begin
            if (w_s) begin
               w_state_nxt = S_LOW_CHK;
               w_cnt_nxt   = '0;
            end
         end
         S_LOW_CHK: begin
            if (!w_s) begin
               w_state_nxt = S_LOW;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = '0;
               w_rise      = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (!w_s) begin
               w_state_nxt = S_HIGH_CHK;
               w_cnt_nxt   = '0;
            end
         end
         S_HIGH_CHK: begin
            if (w_s) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_LOW;
               w_cnt_nxt   = '0;
               w_fall      = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they flip on the commit edge itself.
   assign w_level = (w_state_nxt == S_HIGH) || (w_state_nxt == S_HIGH_CHK);
   assign w_busy  = (w_state_nxt == S_LOW_CHK) || (w_state_nxt == S_HIGH_CHK);

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_level <= w_level;
         r_rise  <= w_rise;
         r_fall  <= w_fall;
         r_busy  <= w_busy;
      end
   end

   // Clear beats a coincident press: that press is deliberately dropped.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         r_press <= '0;
      end else if (CountClr) begin
         r_press <= '0;
      end else if (w_rise) begin
         r_press <= r_press + COUNT_W'(1);
      end
   end

   assign Level      = r_level;
   assign Rise       = r_rise;
   assign Fall       = r_fall;
   assign Busy       = r_busy;
   assign PressCount = r_press;

endmodule

// File: tb/tb_btn_debounce_sync.sv
// Scoreboard bench for btn_debounce_sync: a run-length reference model queues
// expected strobes, a monitor pops and compares them as the DUT emits them.
module tb_btn_debounce_sync;

   localparam int SYNC = 2;
   localparam int DC   = 4;
   localparam int CW   = 8;

   logic          Clk = 1'b0;
   logic          Resetn;
   logic          BtnIn;
   logic          CountClr;
   logic          Level;
   logic          Rise;
   logic          Fall;
   logic          Busy;
   logic [CW-1:0] PressCount;

   int checks = 0;
   int errors = 0;

   btn_debounce_sync #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DC),
      .ACTIVE_LOW      (1'b1),
      .COUNT_W         (CW)
   ) dut (
      .Clk        (Clk),
      .Resetn     (Resetn),
      .BtnIn      (BtnIn),
      .CountClr   (CountClr),
      .Level      (Level),
      .Rise       (Rise),
      .Fall       (Fall),
      .Busy       (Busy),
      .PressCount (PressCount)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the debouncer sees the pressed state SYNC edges late and
   // commits once DC+1 consecutive samples disagree with the current level.
   typedef struct {
      int cyc;
      bit rise;
      int cnt;
   } ev_t;

   ev_t sb[$];
   bit  mq[$] = '{0, 0};
   int  m_level = 0;
   int  m_run   = 0;
   int  m_cnt   = 0;
   int  cyc_n   = 0;

   always @(posedge Clk) begin
      bit x;
      bit fired;
      cyc_n++;
      if (!Resetn) begin
         mq.delete();
         for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
         m_level = 0;
         m_run   = 0;
         m_cnt   = 0;
      end else begin
         x = mq.pop_front();
         mq.push_back(!BtnIn);
         fired = 1'b0;
         if (int'(x) == m_level) begin
            m_run = 0;
         end else begin
            m_run++;
            if (m_run == DC + 1) begin
               m_level = int'(x);
               m_run   = 0;
               fired   = 1'b1;
            end
         end
         if (CountClr) m_cnt = 0;
         else if (fired && x) m_cnt = (m_cnt + 1) % (1 << CW);
         if (fired) sb.push_back('{cyc: cyc_n, rise: x, cnt: m_cnt});
      end
   end

   // Monitor: consumes expected strobes as the DUT presents them.
   always @(posedge Clk) begin
      ev_t e;
      #1;
      while (sb.size() > 0 && sb[0].cyc < cyc_n) begin
         e = sb.pop_front();
         chk("strobe_missing_at_cycle", 32'(e.cyc), 32'hFFFF_FFFF);
      end
      if (Rise || Fall) begin
         if (sb.size() == 0) begin
            chk("strobe_spurious", {30'd0, Rise, Fall}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("strobe_cycle", 32'(cyc_n), 32'(e.cyc));
            chk("strobe_kind_rise", 32'(Rise), 32'(e.rise));
            chk("strobe_kind_fall", 32'(Fall), 32'(!e.rise));
            chk("strobe_count", 32'(PressCount), 32'(e.cnt));
         end
      end
      chk("level", 32'(Level), 32'(m_level));
      chk("busy", 32'(Busy), 32'(m_run > 0));
      chk("press_count", 32'(PressCount), 32'(m_cnt));
   end

   task automatic cyc(input logic btn, input logic clr);
      @(negedge Clk);
      BtnIn    = btn;
      CountClr = clr;
      @(posedge Clk);
      #1;
   endtask

   // i = edges after the first capture of the new value (0 = edge k).
   task automatic qual_check(input int i, input bit up);
      if (i >= 2) chk("q_busy", 32'(Busy), 32'(i <= 5));
      chk("q_level", 32'(Level), up ? 32'(i >= 6) : 32'(i < 6));
      chk("q_rise", 32'(Rise), 32'(up && i == 6));
      chk("q_fall", 32'(Fall), 32'(!up && i == 6));
   endtask

   initial begin
      Resetn   = 1'b0;
      BtnIn    = 1'b1;
      CountClr = 1'b0;
      repeat (3) cyc(1'b1, 1'b0);
      chk("reset_outputs", {27'd0, Level, Rise, Fall, Busy, 1'b0}, 32'd0);
      chk("reset_count", 32'(PressCount), 32'd0);
      @(negedge Clk);
      Resetn = 1'b1;
      repeat (4) cyc(1'b1, 1'b0);

      // Clean press
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0);
         qual_check(i, 1'b1);
      end
      chk("press1_count", 32'(PressCount), 32'd1);

      // Release
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0);
         qual_check(i, 1'b0);
      end
      chk("release_count", 32'(PressCount), 32'd1);

      // Bounce before settling pressed
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0);
         qual_check(i, 1'b1);
      end
      chk("bounce_count", 32'(PressCount), 32'd2);
      repeat (10) cyc(1'b1, 1'b0);

      // Reset in the middle of a qualification, button kept pressed
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
      chk("pre_reset_busy", 32'(Busy), 32'd1);
      @(negedge Clk);
      Resetn = 1'b0;
      #1;
      chk("async_reset_outputs", {28'd0, Level, Rise, Fall, Busy}, 32'd0);
      chk("async_reset_count", 32'(PressCount), 32'd0);
      repeat (3) cyc(1'b0, 1'b0);
      @(negedge Clk);
      Resetn = 1'b1;
      @(posedge Clk);
      #1;
      qual_check(0, 1'b1);
      for (int i = 1; i < 8; i++) begin
         cyc(1'b0, 1'b0);
         qual_check(i, 1'b1);
      end
      chk("held_reset_count", 32'(PressCount), 32'd1);
      repeat (10) cyc(1'b1, 1'b0);

      // Clear, wrap, then clear coincident with a Rise
      cyc(1'b1, 1'b1);
      chk("clear_count", 32'(PressCount), 32'd0);
      repeat (256) begin
         repeat (8) cyc(1'b0, 1'b0);
         repeat (8) cyc(1'b1, 1'b0);
      end
      chk("wrap_count", 32'(PressCount), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, (i == 6));
         qual_check(i, 1'b1);
         if (i >= 6) chk("clr_vs_rise_count", 32'(PressCount), 32'd0);
      end
      repeat (10) cyc(1'b1, 1'b0);

      // Short glitches never commit
      repeat (20) begin
         repeat (3) begin
            cyc(1'b0, 1'b0);
            chk("glitch_quiet", {29'd0, Level, Rise, Fall}, 32'd0);
         end
         repeat (3) begin
            cyc(1'b1, 1'b0);
            chk("glitch_quiet", {29'd0, Level, Rise, Fall}, 32'd0);
         end
      end

      // Random bouncing runs with occasional clears
      for (int n = 0; n < 150; n++) begin
         logic v;
         int   len;
         v   = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 8));
         for (int j = 0; j < len; j++) cyc(v, ($urandom_range(0, 39) == 0));
      end
      repeat (12) cyc(1'b1, 1'b0);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
